// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked ALU with a WIDTH-cycle shift-add multiplier.
// Single-cycle ops complete on the accept edge; MUL holds the unit busy for
// WIDTH cycles and returns the full 2*WIDTH product as {result_hi, result}.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [3:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             cout,
    output logic             ovf,
    output logic             sign,
    output logic             zero,
    output logic             err
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t             state;
    state_t             state_next;
    logic               accept;
    logic               is_mul;
    logic               mul_last;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     step_sum;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sub_diff;
    logic               shift_oob;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_cout;
    logic               alu_ovf;
    logic               alu_err;

    assign accept   = in_valid && in_ready;
    assign is_mul   = (sel == 4'd8);
    assign mul_last = (count == CW'(1));
    assign sign     = result[WIDTH-1];

    // State register; reset aborts any multiply in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic for the IDLE / MUL / DONE sequencing.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) state_next = is_mul ? S_MUL : S_DONE;
            end
            S_MUL: begin
                if (mul_last) state_next = S_DONE;
            end
            S_DONE: begin
                if (accept)         state_next = is_mul ? S_MUL : S_DONE;
                else if (out_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Handshake outputs: out_valid comes straight from the state register.
    always_comb begin
        out_valid = (state == S_DONE);
        in_ready  = (state != S_MUL) && ((state != S_DONE) || out_ready);
    end

    // Single-cycle operations and their flags.
    always_comb begin
        add_sum   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        sub_diff  = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
        shift_oob = (b >= WIDTH'(WIDTH));
        shamt     = b[SHW-1:0];
        alu_res   = '0;
        alu_cout  = 1'b0;
        alu_ovf   = 1'b0;
        alu_err   = 1'b0;
        case (sel)
            4'd0: begin
                alu_res  = add_sum[WIDTH-1:0];
                alu_cout = add_sum[WIDTH];
                alu_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
            end
            4'd1: begin
                // Bit WIDTH of the widened difference is the borrow.
                alu_res  = sub_diff[WIDTH-1:0];
                alu_cout = sub_diff[WIDTH];
                alu_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (sub_diff[WIDTH-1] != a[WIDTH-1]);
            end
            4'd2: alu_res = a & b;
            4'd3: alu_res = a | b;
            4'd4: alu_res = a ^ b;
            4'd5: alu_res = ~a;
            4'd6: alu_res = shift_oob ? '0 : (a << shamt);
            4'd7: alu_res = shift_oob ? '0 : (a >> shamt);
            4'd8: alu_res = '0;
            4'd9: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: alu_err = 1'b1;
        endcase
    end

    // One shift-add step: conditionally add multiplicand to the upper half,
    // then shift {carry, accumulator} right by one.
    always_comb begin
        step_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        acc_step = {step_sum, acc[WIDTH-1:1]};
    end

    // Datapath: multiplier iteration and result/flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            mcand     <= '0;
            acc       <= '0;
            result    <= '0;
            result_hi <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            err       <= 1'b0;
        end else if (state == S_MUL) begin
            acc   <= acc_step;
            count <= count - CW'(1);
            if (mul_last) begin
                result    <= acc_step[WIDTH-1:0];
                result_hi <= acc_step[2*WIDTH-1:WIDTH];
                cout      <= 1'b0;
                ovf       <= 1'b0;
                err       <= 1'b0;
                zero      <= (acc_step == '0);
            end
        end else if (accept) begin
            if (is_mul) begin
                count <= CW'(WIDTH);
                mcand <= a;
                acc   <= {{WIDTH{1'b0}}, b};
            end else begin
                result    <= alu_res;
                result_hi <= '0;
                cout      <= alu_cout;
                ovf       <= alu_ovf;
                err       <= alu_err;
                zero      <= (alu_res == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed literal checks plus randomized traffic compared every
// cycle against a transaction-level reference model.
module tb_alu_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic [3:0]   sel = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         cout, ovf, sign, zero, err;

    logic         in_valid8 = 1'b0;
    logic         in_ready8;
    logic [7:0]   a8 = '0;
    logic [7:0]   b8 = '0;
    logic [3:0]   sel8 = 4'd8;
    logic         out_valid8;
    logic [7:0]   result8, result_hi8;
    logic         cout8, ovf8, sign8, zero8, err8;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sel(sel), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .result_hi(result_hi),
        .cout(cout), .ovf(ovf), .sign(sign), .zero(zero), .err(err)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(1'b0), .sel(sel8), .out_valid(out_valid8),
        .out_ready(1'b1), .result(result8), .result_hi(result_hi8),
        .cout(cout8), .ovf(ovf8), .sign(sign8), .zero(zero8), .err(err8)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         cout;
        logic         ovf;
        logic         zero;
        logic         err;
    } exp_t;

    function automatic exp_t model_op(input logic [3:0] s, input logic [W-1:0] x,
                                      input logic [W-1:0] y, input logic c);
        exp_t            e;
        longint unsigned u;
        longint          sg;
        e  = '0;
        u  = 0;
        sg = 0;
        case (s)
            4'd0: begin
                u      = 64'(x) + 64'(y) + 64'(c);
                e.lo   = u[31:0];
                e.cout = u[32];
                sg     = 64'($signed(x)) + 64'($signed(y)) + 64'(c);
                e.ovf  = (sg > 64'sd2147483647) || (sg < -64'sd2147483648);
            end
            4'd1: begin
                u      = 64'(x) - 64'(y) - 64'(c);
                e.lo   = u[31:0];
                e.cout = (64'(x) < 64'(y) + 64'(c));
                sg     = 64'($signed(x)) - 64'($signed(y)) - 64'(c);
                e.ovf  = (sg > 64'sd2147483647) || (sg < -64'sd2147483648);
            end
            4'd2: e.lo = x & y;
            4'd3: e.lo = x | y;
            4'd4: e.lo = x ^ y;
            4'd5: e.lo = ~x;
            4'd6: e.lo = (y >= 32) ? '0 : (x << y);
            4'd7: e.lo = (y >= 32) ? '0 : (x >> y);
            4'd8: begin
                u    = 64'(x) * 64'(y);
                e.hi = u[63:32];
                e.lo = u[31:0];
            end
            4'd9: e.lo = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            default: e.err = 1'b1;
        endcase
        if (s == 4'd8) e.zero = (u == 0);
        else           e.zero = (e.lo == '0);
        return e;
    endfunction

    exp_t m_exp = '0;
    exp_t m_pend = '0;
    logic m_valid = 1'b0;
    int   m_mulrem = 0;
    logic m_rdy;

    // Model: result pending flag, remaining busy cycles of a multiply.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid  = 1'b0;
            m_mulrem = 0;
            m_exp    = '0;
        end else begin
            m_rdy = (m_mulrem == 0) && (!m_valid || out_ready);
            if (m_mulrem > 0) begin
                m_mulrem--;
                if (m_mulrem == 0) begin
                    m_valid = 1'b1;
                    m_exp   = m_pend;
                end
            end else if (in_valid && m_rdy) begin
                if (sel == 4'd8) begin
                    m_pend   = model_op(sel, a, b, cin);
                    m_mulrem = W;
                    m_valid  = 1'b0;
                end else begin
                    m_exp   = model_op(sel, a, b, cin);
                    m_valid = 1'b1;
                end
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Compare DUT to model every cycle, just after the active edge.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            check("reset_outs", {out_valid, result_hi, result, cout, ovf, sign, zero, err}, '0);
        end else begin
            check("in_ready", in_ready, (m_mulrem == 0) && (!m_valid || out_ready));
            check("out_valid", out_valid, m_valid);
            if (m_valid)
                check("outputs", {result_hi, result, cout, ovf, sign, zero, err},
                      {m_exp.hi, m_exp.lo, m_exp.cout, m_exp.ovf, m_exp.lo[W-1], m_exp.zero, m_exp.err});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [3:0] s, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic c, input logic ordy, output int waits);
        @(negedge clk);
        in_valid = 1'b1; sel = s; a = x; b = y; cin = c; out_ready = ordy;
        #1;
        waits = 0;
        while (!in_ready && waits < 100) begin
            @(negedge clk);
            waits++;
            if (waits > 2) out_ready = 1'b1;
            #1;
        end
        check("issue_accept", in_ready, 1'b1);
        @(posedge clk);
        #2;
        in_valid = 1'b0; a = $urandom; b = $urandom; sel = 4'($urandom); cin = 1'($urandom);
    endtask

    task automatic wait_out(input int maxc, output int lat, output int rdy_seen);
        lat = 0;
        rdy_seen = 0;
        @(negedge clk);
        while (!out_valid && lat < maxc) begin
            if (in_ready) rdy_seen++;
            @(negedge clk);
            lat++;
        end
        check("wait_out_valid", out_valid, 1'b1);
    endtask

    task automatic mul8(input logic [7:0] x, input logic [7:0] y, output int lat);
        @(negedge clk);
        in_valid8 = 1'b1; sel8 = 4'd8; a8 = x; b8 = y;
        #1;
        check("mul8_ready", in_ready8, 1'b1);
        @(posedge clk);
        #2;
        in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        lat = 0;
        @(negedge clk);
        while (!out_valid8 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("mul8_valid", out_valid8, 1'b1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int w, lat, rs, seen;
        logic [3:0]   s;
        logic [W-1:0] y;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_state", {out_valid, result, result_hi, zero, err}, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", in_ready, 1'b1);

        // 8-bit multiplier instance
        mul8(8'd13, 8'd11, lat);
        $display("mul8 13x11 lat=%0d res=%0d hi=%0d", lat, result8, result_hi8);
        check("mul8_lat", lat, 8);
        check("mul8_prod", {result_hi8, result8}, {8'd0, 8'd143});
        mul8(8'd0, 8'd200, lat);
        $display("mul8 0x200 lat=%0d zero=%0b", lat, zero8);
        check("mul8_zero", {zero8, result_hi8, result8}, {1'b1, 16'd0});

        // ADD with carry out
        issue(4'd0, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1, w);
        wait_out(5, lat, rs);
        $display("add ffffffff+0+1 lat=%0d res=%h cout=%0b", lat, result, cout);
        check("add_lat", lat, 0);
        check("add_carry", {result, cout, zero, ovf}, {32'h0, 1'b1, 1'b1, 1'b0});

        issue(4'd0, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b1, w);
        wait_out(5, lat, rs);
        $display("add 7fffffff+1 res=%h ovf=%0b", result, ovf);
        check("add_ovf", {result, ovf, sign, cout}, {32'h80000000, 1'b1, 1'b1, 1'b0});

        issue(4'd1, 32'd3, 32'd5, 1'b0, 1'b1, w);
        wait_out(5, lat, rs);
        $display("sub 3-5 res=%h cout=%0b", result, cout);
        check("sub_borrow", {result, cout, sign}, {32'hFFFFFFFE, 1'b1, 1'b1});

        issue(4'd9, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b1, w);
        wait_out(5, lat, rs);
        $display("slt -1<1 res=%h", result);
        check("slt", result, 32'd1);

        // Full-width multiply
        issue(4'd8, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, w);
        wait_out(40, lat, rs);
        $display("mul ffffffff^2 lat=%0d hi=%h lo=%h", lat, result_hi, result);
        check("mul_lat", lat, W);
        check("mul_ready_busy", rs, 0);
        check("mul_prod", {result_hi, result}, {32'hFFFFFFFE, 32'h00000001});

        // Backpressure then same-edge streaming
        issue(4'd0, 32'd5, 32'd6, 1'b0, 1'b0, w);
        wait_out(5, lat, rs);
        repeat (3) begin
            @(negedge clk); #1;
            check("bp_hold", {out_valid, in_ready, result}, {1'b1, 1'b0, 32'd11});
        end
        issue(4'd4, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 1'b1, w);
        check("stream_waits", w, 0);
        wait_out(5, lat, rs);
        $display("xor stream waits=%0d lat=%0d res=%h", w, lat, result);
        check("stream_xor", {lat[3:0], result}, {4'd0, 32'hFF00FF00});

        issue(4'd6, 32'd1, 32'd32, 1'b0, 1'b1, w);
        wait_out(5, lat, rs);
        $display("shl 1<<32 res=%h", result);
        check("shl_oob", {result, zero}, {32'h0, 1'b1});

        // Reset in the middle of a multiply
        issue(4'd0, 32'd5, 32'd6, 1'b0, 1'b1, w);
        issue(4'd8, $urandom, $urandom, 1'b0, 1'b1, w);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        $display("reset during mul res=%h valid=%0b", result, out_valid);
        check("rst_abort_outs", {out_valid, result, result_hi, cout, ovf, sign, zero, err}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_release_ready", in_ready, 1'b1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rst_no_result", seen, 0);

        issue(4'd12, $urandom, $urandom, 1'b1, 1'b1, w);
        wait_out(5, lat, rs);
        $display("illegal sel=12 lat=%0d err=%0b res=%h", lat, err, result);
        check("illegal", {lat[3:0], err, result}, {4'd0, 1'b1, 32'h0});

        // Randomized traffic, checked by the per-cycle compare process
        for (int i = 0; i < 400; i++) begin
            s = 4'($urandom_range(0, 15));
            if (s == 4'd8 && $urandom_range(0, 3) != 0) s = 4'($urandom_range(0, 7));
            y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            issue(s, $urandom, y, 1'($urandom), 1'($urandom_range(0, 1)), w);
            $display("rand %0d sel=%0d b=%h waits=%0d", i, s, y, w);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        out_ready = 1'b1;
        repeat (50) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
